// File: rtl/sdram_burst_wr.sv
// SDRAM burst write engine: ACT/WRITE/PRECHARGE sequencing with row crossing,
// refresh break/resume at the next column, and FIFO-starvation gaps.
module sdram_burst_wr #(
    parameter int DATA_W    = 16,
    parameter int ROW_W     = 12,
    parameter int COL_W     = 9,
    parameter int BANK_W    = 2,
    parameter int BURST_LEN = 4,
    parameter int T_RCD     = 2,
    parameter int T_WR      = 2,
    parameter int T_RP      = 2,
    parameter int LEN_W     = 16
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              wr_trig,
    input  logic [BANK_W-1:0] start_bank,
    input  logic [ROW_W-1:0]  start_row,
    input  logic [COL_W-1:0]  start_col,
    input  logic [LEN_W-1:0]  num_bursts,
    output logic              wr_req,
    input  logic              wr_en,
    input  logic              ref_req,
    input  logic              din_avail,
    input  logic [DATA_W-1:0] din_data,
    output logic              din_rd,
    output logic [3:0]        wr_cmd,
    output logic [ROW_W-1:0]  wr_addr,
    output logic [BANK_W-1:0] bank_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              flag_wr_end,
    output logic              done,
    output logic              busy
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] ACT  = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] PRE  = 3'd4;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;

    localparam logic [1:0] C_FIN = 2'd0;
    localparam logic [1:0] C_BRK = 2'd1;
    localparam logic [1:0] C_ROW = 2'd2;

    localparam int CNT_W  = $clog2(T_RCD + T_WR + T_RP + 1);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    // Burst-aligned column mask; also the last burst-start column of a row.
    localparam logic [COL_W-1:0] COL_MASK = ~COL_W'(BURST_LEN - 1);
    localparam logic [ROW_W-1:0] A10      = ROW_W'(1) << 10;

    logic [2:0]        state;
    logic [CNT_W-1:0]  tcnt;
    logic [BEAT_W-1:0] beat;
    logic [LEN_W-1:0]  rem;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic              row_chg;
    logic [1:0]        cause;

    logic boundary;
    logic go_fin;
    logic go_brk;
    logic go_row;
    logic go_wr;
    logic pre_now;
    logic pre_exit;

    // Burst boundary: last T_RCD cycle of ACT, or WR with no beats left.
    always_comb begin
        boundary = (state == ACT && tcnt == CNT_W'(T_RCD - 1))
                || (state == WR && beat == '0);
        go_fin   = boundary && rem == '0;
        go_brk   = boundary && !go_fin && ref_req;
        go_row   = boundary && !go_fin && !go_brk && row_chg;
        go_wr    = boundary && !go_fin && !go_brk && !go_row && din_avail;
        pre_now  = state == PRE && tcnt == CNT_W'(T_WR - 1);
        pre_exit = state == PRE && tcnt == CNT_W'(T_WR + T_RP - 1);
    end

    assign din_rd = go_wr || (state == WR && beat != '0);

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state       <= IDLE;
            tcnt        <= '0;
            beat        <= '0;
            rem         <= '0;
            bank        <= '0;
            row         <= '0;
            col         <= '0;
            row_chg     <= 1'b0;
            cause       <= C_FIN;
            wr_req      <= 1'b0;
            wr_cmd      <= CMD_NOP;
            wr_addr     <= '0;
            bank_addr   <= '0;
            wr_data     <= '0;
            flag_wr_end <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            flag_wr_end <= 1'b0;
            done        <= 1'b0;
            wr_cmd      <= CMD_NOP;
            wr_req      <= (state == REQ) && !(wr_req && wr_en);
            if (din_rd) wr_data <= din_data;

            unique case (state)
                IDLE: begin
                    if (wr_trig) begin
                        bank    <= start_bank;
                        row     <= start_row;
                        col     <= start_col & COL_MASK;
                        rem     <= num_bursts;
                        row_chg <= 1'b0;
                        if (num_bursts == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= REQ;
                            busy  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (wr_req && wr_en) begin
                        state     <= ACT;
                        tcnt      <= '0;
                        wr_cmd    <= CMD_ACT;
                        wr_addr   <= row;
                        bank_addr <= bank;
                        row_chg   <= 1'b0;
                    end
                end
                ACT: begin
                    tcnt <= tcnt + CNT_W'(1);
                    if (boundary) state <= WR;
                end
                WR: begin
                    if (beat != '0) beat <= beat - BEAT_W'(1);
                end
                PRE: begin
                    tcnt <= tcnt + CNT_W'(1);
                    if (pre_now) begin
                        wr_cmd  <= CMD_PRE;
                        wr_addr <= A10;
                    end
                    if (pre_exit) begin
                        unique case (cause)
                            C_ROW: begin
                                state     <= ACT;
                                tcnt      <= '0;
                                wr_cmd    <= CMD_ACT;
                                wr_addr   <= row;
                                bank_addr <= bank;
                                row_chg   <= 1'b0;
                            end
                            C_BRK: begin
                                state       <= REQ;
                                flag_wr_end <= 1'b1;
                            end
                            default: begin
                                state       <= IDLE;
                                flag_wr_end <= 1'b1;
                                done        <= 1'b1;
                                busy        <= 1'b0;
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase

            // Row is advanced as soon as its last burst starts; the open row
            // is closed with an all-bank precharge so only the next ACT uses it.
            if (go_wr) begin
                wr_cmd    <= CMD_WR;
                wr_addr   <= ROW_W'(col);
                bank_addr <= bank;
                beat      <= BEAT_W'(BURST_LEN - 1);
                rem       <= rem - LEN_W'(1);
                col       <= col + COL_W'(BURST_LEN);
                if (col == COL_MASK) begin
                    row_chg <= 1'b1;
                    row     <= row + ROW_W'(1);
                end
            end

            if (go_fin || go_brk || go_row) begin
                state <= PRE;
                tcnt  <= '0;
                cause <= go_fin ? C_FIN : (go_brk ? C_BRK : C_ROW);
            end
        end
    end

endmodule

// File: tb/tb_sdram_burst_wr.sv
// Directed bench for sdram_burst_wr: command trace, data order, pulses.
module tb_sdram_burst_wr;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] WRC = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;

    logic        sclk = 1'b0;
    logic        s_rst = 1'b1;
    logic        wr_trig = 1'b0;
    logic [1:0]  start_bank = '0;
    logic [11:0] start_row = '0;
    logic [8:0]  start_col = '0;
    logic [15:0] num_bursts = '0;
    logic        wr_req;
    logic        wr_en = 1'b0;
    logic        ref_req = 1'b0;
    logic        din_avail = 1'b0;
    logic [15:0] din_data;
    logic        din_rd;
    logic [3:0]  wr_cmd;
    logic [11:0] wr_addr;
    logic [1:0]  bank_addr;
    logic [15:0] wr_data;
    logic        flag_wr_end;
    logic        done;
    logic        busy;

    sdram_burst_wr dut (
        .sclk(sclk), .s_rst(s_rst), .wr_trig(wr_trig),
        .start_bank(start_bank), .start_row(start_row),
        .start_col(start_col), .num_bursts(num_bursts),
        .wr_req(wr_req), .wr_en(wr_en), .ref_req(ref_req),
        .din_avail(din_avail), .din_data(din_data), .din_rd(din_rd),
        .wr_cmd(wr_cmd), .wr_addr(wr_addr), .bank_addr(bank_addr),
        .wr_data(wr_data), .flag_wr_end(flag_wr_end), .done(done),
        .busy(busy)
    );

    always #5 sclk = ~sclk;

    int tests = 0;
    int fails = 0;

    // FIFO model: head word is a running index, popped on din_rd.
    int widx = 0;
    assign din_data = 16'hA000 + 16'(widx);
    always @(posedge sclk) if (din_rd === 1'b1) widx <= widx + 1;

    // Capture BURST_LEN words starting with each WR command.
    logic [15:0] data_q[$];
    int dleft = 0;
    int n_done = 0;
    int n_flag = 0;
    always @(negedge sclk) begin
        if (s_rst) begin
            dleft = 0;
        end else begin
            if (wr_cmd == WRC) dleft = 4;
            if (dleft > 0) begin
                data_q.push_back(wr_data);
                dleft--;
            end
        end
        if (done === 1'b1) n_done++;
        if (flag_wr_end === 1'b1) n_flag++;
    end

    logic [16:0] eq[$];
    logic [1:0]  ebank;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    function automatic void e(logic [3:0] c, logic [11:0] a);
        eq.push_back({1'b1, c, a});
    endfunction

    function automatic void nops(int n);
        for (int i = 0; i < n; i++) eq.push_back({1'b0, NOP, 12'h0});
    endfunction

    function automatic void burst(int c);
        e(WRC, 12'(c));
        nops(3);
    endfunction

    // T_WR NOPs, PRE, NOP, then the exit cycle.
    function automatic void tail();
        nops(2);
        e(PRE, 12'h400);
        nops(2);
    endfunction

    task automatic run_seq(input string tag);
        logic [16:0] x;
        while (eq.size() > 0) begin
            x = eq.pop_front();
            step();
            wr_en = 1'b0;
            chk({tag, ".cmd"}, 32'(wr_cmd), 32'(x[15:12]));
            chk({tag, ".req"}, 32'(wr_req), 32'd0);
            if (x[16]) begin
                chk({tag, ".addr"}, 32'(wr_addr), 32'(x[11:0]));
                if (x[15:12] != PRE)
                    chk({tag, ".bank"}, 32'(bank_addr), 32'(ebank));
            end
        end
    endtask

    task automatic start(input logic [1:0] b, input logic [11:0] r,
                         input logic [8:0] c, input logic [15:0] n);
        start_bank = b;
        start_row  = r;
        start_col  = c;
        num_bursts = n;
        ebank      = b;
        wr_trig    = 1'b1;
        step();
        wr_trig    = 1'b0;
    endtask

    task automatic grant(input int lat);
        int n;
        n = 0;
        while (wr_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", 32'(wr_req), 32'd1);
        repeat (lat) step();
        wr_en = 1'b1;
    endtask

    task automatic chk_data(input string tag, input int base, input int n);
        chk({tag, ".nwords"}, 32'(data_q.size()), 32'(n));
        for (int i = 0; i < data_q.size() && i < n; i++)
            chk({tag, ".word"}, 32'(data_q[i]), 32'(16'(32'hA000 + base + i)));
        data_q.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".cmd"},  32'(wr_cmd), 32'(NOP));
        chk({tag, ".addr"}, 32'(wr_addr), 32'd0);
        chk({tag, ".bank"}, 32'(bank_addr), 32'd0);
        chk({tag, ".data"}, 32'(wr_data), 32'd0);
        chk({tag, ".req"},  32'(wr_req), 32'd0);
        chk({tag, ".rd"},   32'(din_rd), 32'd0);
        chk({tag, ".flag"}, 32'(flag_wr_end), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int d0;
        int f0;

        step();
        step();
        chk_reset("rst");
        s_rst = 1'b0;
        step();

        // Basic two-burst write.
        din_avail = 1'b1;
        base = widx;
        d0 = n_done;
        f0 = n_flag;
        start(2'd1, 12'd5, 9'd0, 16'd2);
        chk("t1.busy", 32'(busy), 32'd1);
        chk("t1.req0", 32'(wr_req), 32'd0);
        grant(3);
        e(ACT, 12'd5); nops(1); burst(0); burst(4); tail();
        run_seq("t1");
        chk("t1.flag", 32'(flag_wr_end), 32'd1);
        chk("t1.done", 32'(done), 32'd1);
        chk("t1.busy_end", 32'(busy), 32'd0);
        step();
        chk("t1.done_low", 32'(done), 32'd0);
        chk("t1.ndone", 32'(n_done - d0), 32'd1);
        chk("t1.nflag", 32'(n_flag - f0), 32'd1);
        chk_data("t1", base, 8);

        // Row crossing without re-arbitration.
        base = widx;
        f0 = n_flag;
        start(2'd2, 12'd7, 9'd504, 16'd4);
        grant(1);
        e(ACT, 12'd7); nops(1); burst(504); burst(508);
        nops(2); e(PRE, 12'h400); nops(1);
        e(ACT, 12'd8); nops(1); burst(0); burst(4); tail();
        run_seq("t2");
        chk("t2.done", 32'(done), 32'd1);
        step();
        chk("t2.nflag", 32'(n_flag - f0), 32'd1);
        chk_data("t2", base, 16);

        // Refresh break during the second burst, resume at column 8.
        base = widx;
        d0 = n_done;
        f0 = n_flag;
        start(2'd3, 12'd100, 9'd0, 16'd6);
        grant(2);
        e(ACT, 12'd100); nops(1); burst(0); e(WRC, 12'd4);
        run_seq("t3a");
        ref_req = 1'b1;
        nops(3); tail();
        run_seq("t3b");
        chk("t3.flag", 32'(flag_wr_end), 32'd1);
        chk("t3.nodone", 32'(done), 32'd0);
        chk("t3.busy", 32'(busy), 32'd1);
        ref_req = 1'b0;
        step();
        chk("t3.rereq", 32'(wr_req), 32'd1);
        wr_en = 1'b1;
        e(ACT, 12'd100); nops(1);
        burst(8); burst(12); burst(16); burst(20); tail();
        run_seq("t3c");
        chk("t3.done", 32'(done), 32'd1);
        step();
        chk("t3.nflag", 32'(n_flag - f0), 32'd2);
        chk("t3.ndone", 32'(n_done - d0), 32'd1);
        chk_data("t3", base, 24);

        // Data starvation gap of five cycles.
        base = widx;
        start(2'd1, 12'd9, 9'd0, 16'd2);
        grant(1);
        e(ACT, 12'd9); nops(1); burst(0);
        run_seq("t4a");
        din_avail = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t4.rd", 32'(din_rd), 32'd0);
            step();
            chk("t4.gap", 32'(wr_cmd), 32'(NOP));
        end
        din_avail = 1'b1;
        burst(4); tail();
        run_seq("t4b");
        chk("t4.done", 32'(done), 32'd1);
        step();
        chk_data("t4", base, 8);

        // Refresh arriving during a starvation gap.
        base = widx;
        start(2'd0, 12'd11, 9'd0, 16'd2);
        grant(1);
        e(ACT, 12'd11); nops(1); burst(0);
        run_seq("t5a");
        din_avail = 1'b0;
        nops(2);
        run_seq("t5b");
        ref_req = 1'b1;
        tail();
        run_seq("t5c");
        chk("t5.flag", 32'(flag_wr_end), 32'd1);
        chk("t5.nodone", 32'(done), 32'd0);
        ref_req = 1'b0;
        din_avail = 1'b1;
        grant(1);
        e(ACT, 12'd11); nops(1); burst(4); tail();
        run_seq("t5d");
        chk("t5.done", 32'(done), 32'd1);
        step();
        chk_data("t5", base, 8);

        // Asynchronous reset in the middle of a burst.
        start(2'd2, 12'd30, 9'd0, 16'd3);
        grant(1);
        e(ACT, 12'd30); nops(1); e(WRC, 12'd0);
        run_seq("t6a");
        step();
        #2 s_rst = 1'b1;
        #1;
        chk_reset("t6.rst");
        step();
        s_rst = 1'b0;
        step();
        data_q.delete();
        base = widx;
        start(2'd1, 12'd5, 9'd0, 16'd2);
        grant(2);
        e(ACT, 12'd5); nops(1); burst(0); burst(4); tail();
        run_seq("t6b");
        chk("t6.done", 32'(done), 32'd1);
        step();
        chk_data("t6", base, 8);

        // wr_trig while busy is ignored; start column low bits dropped.
        base = widx;
        d0 = n_done;
        start(2'd2, 12'd20, 9'd14, 16'd1);
        grant(1);
        e(ACT, 12'd20); nops(1); e(WRC, 12'd12);
        run_seq("t7a");
        start_bank = 2'd3;
        start_row  = 12'd200;
        start_col  = 9'd40;
        num_bursts = 16'd5;
        wr_trig    = 1'b1;
        step();
        wr_trig    = 1'b0;
        chk("t7.trig_cmd", 32'(wr_cmd), 32'(NOP));
        nops(2); tail();
        run_seq("t7b");
        chk("t7.done", 32'(done), 32'd1);
        chk("t7.busy", 32'(busy), 32'd0);
        step();
        step();
        chk("t7.idle_req", 32'(wr_req), 32'd0);
        chk("t7.ndone", 32'(n_done - d0), 32'd1);
        chk_data("t7", base, 4);

        // Zero-length transfer.
        d0 = n_done;
        start(2'd1, 12'd1, 9'd0, 16'd0);
        chk("t8.done", 32'(done), 32'd1);
        chk("t8.busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t8.req", 32'(wr_req), 32'd0);
        end
        chk("t8.ndone", 32'(n_done - d0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdram_burst_wr.md
# sdram_burst_wr

Parametrised SDRAM write engine: the next generation of the single-purpose fixed-pattern writer. It takes a start bank/row/column and a burst count, requests the SDRAM command bus from the arbiter, and issues ACT/WRITE/PRECHARGE sequences. Write data comes from a show-ahead FIFO. Unlike its predecessor it has runtime addressing, configurable burst length and timing, row crossing without re-arbitration, data-starvation gaps, and refresh break with resume at the exact next column. It sits beside the init/refresh/read engines under the SDRAM top arbiter.

## Interface
- DATA_W, 16, SDRAM DQ width
- ROW_W, 12, row address width (equals SDRAM address bus width)
- COL_W, 9, column address width (COL_W < ROW_W, COL_W ≤ 10)
- BANK_W, 2, bank address width
- BURST_LEN, 4, words per WRITE; power of two, 1..8, ≤ 2^COL_W
- T_RCD, 2, cycles from ACT to first WRITE (≥1)
- T_WR, 2, NOP cycles after last data before PRE (≥1)
- T_RP, 2, cycles from PRE to next ACT or bus release (≥1)
- LEN_W, 16, width of burst count
- sclk  in  1  clock
- s_rst  in  1  reset; asynchronous, active-high
- wr_trig  in  1  start pulse, sampled only in IDLE
- start_bank  in  BANK_W  bank, latched on accepted wr_trig
- start_row  in  ROW_W  row, latched on accepted wr_trig
- start_col  in  COL_W  column, latched; low log2(BURST_LEN) bits treated as 0
- num_bursts  in  LEN_W  bursts to write, latched
- wr_req  out  1  bus request to arbiter
- wr_en  in  1  bus grant from arbiter
- ref_req  in  1  refresh pending
- din_avail  in  1  FIFO holds ≥ BURST_LEN words
- din_data  in  DATA_W  FIFO head word (show-ahead)
- din_rd  out  1  FIFO pop, combinational
- wr_cmd  out  4  {cs_n,ras_n,cas_n,we_n}; NOP 0111, ACT 0011, WR 0100, PRE 0010
- wr_addr  out  ROW_W  SDRAM address
- bank_addr  out  BANK_W  SDRAM bank
- wr_data  out  DATA_W  SDRAM write data
- flag_wr_end  out  1  one-cycle pulse: bus released to arbiter
- done  out  1  one-cycle pulse: whole transfer complete
- busy  out  1  high from accepted wr_trig until done

## Operation
- States: IDLE, REQ, ACT, WR, PRE.
- IDLE: wr_trig latches all start inputs, sets busy, goes to REQ. If num_bursts=0, pulses done instead and stays IDLE.
- REQ: wr_req=1. wr_en sampled high moves to ACT.
- ACT: first cycle issues ACT with wr_addr=row, bank_addr=bank. Then NOP until T_RCD cycles have elapsed, then WR.
- WR, at each burst boundary (WR entry or end of previous burst), checks in priority order:
  1. remaining=0 → PRE (finish).
  2. ref_req → PRE (break).
  3. previous burst ended last column of row → PRE (row change).
  4. din_avail → issue WR with wr_addr={zeros, A10=0, col}. din_rd high BURST_LEN consecutive cycles. Decrement remaining; col += BURST_LEN.
  5. Otherwise NOP, stay in WR (gap); re-evaluate next cycle.
- Once a burst has started, it always completes. ref_req is never acted on mid-burst.
- PRE: T_WR NOP cycles, then PRE with A10=1 (all banks), then T_RP NOP cycles. Exit by cause:
  - finish → IDLE, pulse flag_wr_end and done, clear busy.
  - break → REQ, pulse flag_wr_end.
  - row change → ACT directly, keeping bus ownership.
- Address arithmetic:
  - col wraps 2^COL_W−BURST_LEN → 0 and sets row change.
  - row increments on each row change and wraps 2^ROW_W−1 → 0 within the same bank.
  - Resume after a break uses the saved row/col; no data is lost or duplicated.
- wr_trig outside IDLE is ignored.
- Asynchronous s_rst mid-operation forces IDLE and all outputs to reset values immediately. No PRE is issued.

## Timing
- Reset values: wr_cmd=0111, wr_addr=0, bank_addr=0, wr_data=0, wr_req=0, din_rd=0, flag_wr_end=0, done=0, busy=0.
- wr_cmd, wr_addr, bank_addr, wr_data are registered. wr_req and busy are registered state decodes.
- wr_trig at edge n → wr_req high after edge n+1.
- wr_en high at cycle k → ACT on wr_cmd after edge k+1. wr_req drops the same edge.
- First WR appears T_RCD cycles after ACT.
- din_rd high in cycle m → that din_data appears on wr_data after edge m. The first word coincides with wr_cmd=WR. Words then follow on consecutive cycles.
- Back-to-back bursts have zero gap when din_avail stays high.
- Last data → PRE: T_WR cycles. PRE → flag_wr_end/ACT: T_RP cycles.
- flag_wr_end and done are single-cycle pulses, asserted the cycle state leaves PRE.

## Test plan
- Defaults; bank 1, row 5, col 0, num_bursts=2, din_avail=1, wr_en granted 3 cycles after wr_req:
  - wr_cmd sequence ACT(addr 5, bank 1), NOP, WR(col 0), 3×NOP, WR(col 4), 3×NOP, 2×NOP, PRE(addr 0x400), 2×NOP.
  - 8 FIFO words appear in order; done and flag_wr_end pulse once.
- Row crossing: row 7, col 504, num_bursts=4 → WR at cols 504 and 508, then PRE, ACT row 8 without wr_req, then WR at cols 0 and 4.
- Refresh: ref_req raised during second of 6 bursts → burst completes, PRE, flag_wr_end pulse, wr_req high. After re-grant: ACT same row, WR at next column (col 8), 4 bursts remain.
- Starvation: drop din_avail for 5 cycles after the first burst → 5 extra NOPs, din_rd low throughout, then WR at col 4. ref_req raised during the gap → PRE break.
- Reset: assert s_rst mid-burst → all outputs at reset values within the same cycle. After release, a new wr_trig runs a clean sequence.
- wr_trig pulsed while busy → ignored: latched address unchanged, single done pulse. num_bursts=0 → done pulse, wr_req never high.
